// File: rtl/tri_assembler.sv
// ============================================================================
// Module   : tri_assembler
// Purpose  : Groups a stream of vertex writes into triangles. Each triangle
//            carries the 1/area value current when it is completed, and is
//            queued in a small first-word-fall-through FIFO that feeds the
//            rasterizer through a tri_valid/tri_ready handshake.
//            Triangles whose effective 1/area is zero are degenerate. They
//            are discarded and counted in a saturating drop counter.
// Options  : TRI_STRIP_EN  - when defined, strip_mode=1 builds a triangle
//                            strip: every vertex after the third forms a
//                            triangle with the previous two. Alternate
//                            triangles swap v0/v1 to keep the winding order.
//                            When undefined, strip_mode is ignored.
// Ports    : clk, rst_n              clock, asynchronous active-low reset
//            vtx_valid/vtx_ready     vertex write handshake
//            vtx_x/y/z/color         vertex payload (12.4 X/Y, depth, RGB888)
//            inv_area_wr/inv_area_in load of the 1/area shadow register
//            asm_clear               restart vertex grouping (FIFO is kept)
//            strip_mode              strip assembly select
//            tri_valid/tri_ready     triangle handshake to the rasterizer
//            v0_*/v1_*/v2_*/inv_area head FIFO entry
//            fifo_count, drop_count  occupancy and discarded-triangle count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tri_assembler #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vtx_valid,
    output logic             vtx_ready,
    input  logic [15:0]      vtx_x,
    input  logic [15:0]      vtx_y,
    input  logic [15:0]      vtx_z,
    input  logic [23:0]      vtx_color,
    input  logic             inv_area_wr,
    input  logic [15:0]      inv_area_in,
    input  logic             asm_clear,
    input  logic             strip_mode,
    output logic             tri_valid,
    input  logic             tri_ready,
    output logic [15:0]      v0_x,
    output logic [15:0]      v0_y,
    output logic [15:0]      v0_z,
    output logic [23:0]      v0_color,
    output logic [15:0]      v1_x,
    output logic [15:0]      v1_y,
    output logic [15:0]      v1_z,
    output logic [23:0]      v1_color,
    output logic [15:0]      v2_x,
    output logic [15:0]      v2_y,
    output logic [15:0]      v2_z,
    output logic [23:0]      v2_color,
    output logic [15:0]      inv_area,
    output logic [CNT_W-1:0] fifo_count,
    output logic [15:0]      drop_count
);

    // A vertex is packed as {x, y, z, color}. An entry is {v0, v1, v2, inv_area}.
    localparam int c_VTX_W = 72;
    localparam int c_ENT_W = 3 * c_VTX_W + 16;
    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

`ifdef TRI_STRIP_EN
    typedef enum logic [1:0] {
        ST_V0    = 2'd0,
        ST_V1    = 2'd1,
        ST_V2    = 2'd2,
        ST_STRIP = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_V0 = 2'd0,
        ST_V1 = 2'd1,
        ST_V2 = 2'd2
    } state_t;
`endif

    state_t               r_state;
    state_t               w_next_state;
    logic [c_VTX_W-1:0]   r_slot0;
    logic [c_VTX_W-1:0]   r_slot1;
    logic [15:0]          r_shadow;
    logic [15:0]          r_drop;
    logic [c_ENT_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    logic [c_VTX_W-1:0]   w_vtx;
    logic [c_ENT_W-1:0]   w_entry;
    logic [c_ENT_W-1:0]   w_head;
    logic [15:0]          w_eff_ia;
    logic                 w_full;
    logic                 w_push_state;
    logic                 w_accept;
    logic                 w_form;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;
    logic                 w_ld0;
    logic                 w_ld1;

`ifdef TRI_STRIP_EN
    logic                 r_parity;
    logic                 w_next_parity;
    logic                 w_shift;
`else
    logic                 w_unused_strip_mode;
    assign w_unused_strip_mode = strip_mode;
`endif

    assign w_vtx    = {vtx_x, vtx_y, vtx_z, vtx_color};
    // A 1/area written in the completing cycle already applies to that triangle.
    assign w_eff_ia = inv_area_wr ? inv_area_in : r_shadow;
    // The full flag comes only from registered occupancy. A pop in the same
    // cycle does not reopen vtx_ready, so there is no ready-to-ready path.
    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));

`ifdef TRI_STRIP_EN
    assign w_push_state = (r_state == ST_V2) || ((r_state == ST_STRIP) && strip_mode);
`else
    assign w_push_state = (r_state == ST_V2);
`endif

    assign vtx_ready = !(w_push_state && w_full);
    // asm_clear wins over a vertex arriving in the same cycle.
    assign w_accept  = vtx_valid && vtx_ready && !asm_clear;
    assign w_form    = w_accept && w_push_state;
    assign w_push    = w_form && (w_eff_ia != 16'd0);
    assign w_drop    = w_form && (w_eff_ia == 16'd0);
    assign w_pop     = tri_valid && tri_ready;

`ifdef TRI_STRIP_EN
    // On odd strip triangles, swapping v0/v1 restores the winding order.
    assign w_entry = ((r_state == ST_STRIP) && r_parity)
                   ? {r_slot1, r_slot0, w_vtx, w_eff_ia}
                   : {r_slot0, r_slot1, w_vtx, w_eff_ia};
`else
    assign w_entry = {r_slot0, r_slot1, w_vtx, w_eff_ia};
`endif

    // ------------------------------------------------------------------
    // Assembly FSM: next state and staging-slot controls
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state  = r_state;
        w_ld0         = 1'b0;
        w_ld1         = 1'b0;
`ifdef TRI_STRIP_EN
        w_shift       = 1'b0;
        w_next_parity = r_parity;
`endif
        if (asm_clear) begin
            w_next_state  = ST_V0;
`ifdef TRI_STRIP_EN
            w_next_parity = 1'b0;
`endif
        end else begin
            case (r_state)
                ST_V0: begin
                    if (w_accept) begin
                        w_ld0        = 1'b1;
                        w_next_state = ST_V1;
                    end
                end
                ST_V1: begin
                    if (w_accept) begin
                        w_ld1        = 1'b1;
                        w_next_state = ST_V2;
                    end
                end
                ST_V2: begin
                    if (w_accept) begin
`ifdef TRI_STRIP_EN
                        if (strip_mode) begin
                            // The first triangle counts as even; the next is odd.
                            w_shift       = 1'b1;
                            w_next_state  = ST_STRIP;
                            w_next_parity = 1'b1;
                        end else begin
                            w_next_state  = ST_V0;
                        end
`else
                        w_next_state = ST_V0;
`endif
                    end
                end
`ifdef TRI_STRIP_EN
                ST_STRIP: begin
                    if (!strip_mode) begin
                        // Leaving strip mode: this cycle behaves as V0.
                        w_next_parity = 1'b0;
                        w_next_state  = ST_V0;
                        if (w_accept) begin
                            w_ld0        = 1'b1;
                            w_next_state = ST_V1;
                        end
                    end else if (w_accept) begin
                        w_shift       = 1'b1;
                        w_next_parity = ~r_parity;
                    end
                end
`endif
                default: w_next_state = ST_V0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_V0;
            r_slot0 <= '0;
            r_slot1 <= '0;
`ifdef TRI_STRIP_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            if (w_ld0) begin
                r_slot0 <= w_vtx;
            end
            if (w_ld1) begin
                r_slot1 <= w_vtx;
            end
`ifdef TRI_STRIP_EN
            r_parity <= w_next_parity;
            if (w_shift) begin
                r_slot0 <= r_slot1;
                r_slot1 <= w_vtx;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // 1/area shadow and saturating degenerate-triangle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= 16'd0;
            r_drop   <= 16'd0;
        end else begin
            if (inv_area_wr) begin
                r_shadow <= inv_area_in;
            end
            if (w_drop && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Triangle FIFO. The head is read straight from storage
    // (first-word-fall-through). Storage is reset so that the head
    // outputs read zero after reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign tri_valid  = (r_count != '0);
    assign fifo_count = r_count;
    assign drop_count = r_drop;

    assign v0_x       = w_head[231:216];
    assign v0_y       = w_head[215:200];
    assign v0_z       = w_head[199:184];
    assign v0_color   = w_head[183:160];
    assign v1_x       = w_head[159:144];
    assign v1_y       = w_head[143:128];
    assign v1_z       = w_head[127:112];
    assign v1_color   = w_head[111:88];
    assign v2_x       = w_head[87:72];
    assign v2_y       = w_head[71:56];
    assign v2_z       = w_head[55:40];
    assign v2_color   = w_head[39:16];
    assign inv_area   = w_head[15:0];

endmodule

`default_nettype wire

// File: tb/tb_tri_assembler.sv
// ============================================================================
// Module   : tb_tri_assembler
// Purpose  : Self-checking bench for tri_assembler. It applies a directed
//            vector table, hand-written multi-cycle sequences (full stall,
//            reset mid-operation, optional strip mode) and a random phase,
//            all checked against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tri_assembler;

    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             vtx_valid = 1'b0;
    logic             vtx_ready;
    logic [15:0]      vtx_x = '0, vtx_y = '0, vtx_z = '0;
    logic [23:0]      vtx_color = '0;
    logic             inv_area_wr = 1'b0;
    logic [15:0]      inv_area_in = '0;
    logic             asm_clear = 1'b0;
    logic             strip_mode = 1'b0;
    logic             tri_valid;
    logic             tri_ready = 1'b0;
    logic [15:0]      v0_x, v0_y, v0_z, v1_x, v1_y, v1_z, v2_x, v2_y, v2_z;
    logic [23:0]      v0_color, v1_color, v2_color;
    logic [15:0]      inv_area;
    logic [CNT_W-1:0] fifo_count;
    logic [15:0]      drop_count;

    always #5 clk = ~clk;

    tri_assembler #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .vtx_valid(vtx_valid), .vtx_ready(vtx_ready),
        .vtx_x(vtx_x), .vtx_y(vtx_y), .vtx_z(vtx_z), .vtx_color(vtx_color),
        .inv_area_wr(inv_area_wr), .inv_area_in(inv_area_in),
        .asm_clear(asm_clear), .strip_mode(strip_mode),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .v0_x(v0_x), .v0_y(v0_y), .v0_z(v0_z), .v0_color(v0_color),
        .v1_x(v1_x), .v1_y(v1_y), .v1_z(v1_z), .v1_color(v1_color),
        .v2_x(v2_x), .v2_y(v2_y), .v2_z(v2_z), .v2_color(v2_color),
        .inv_area(inv_area), .fifo_count(fifo_count), .drop_count(drop_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [71:0] v0;
        logic [71:0] v1;
        logic [71:0] v2;
        logic [15:0] ia;
    } tri_t;

    tri_t        mq[$];
    logic [71:0] m_pend[$];    // vertices of the triangle being gathered
    logic [15:0] m_shadow;
    int          m_drop;

    function automatic logic m_ready();
        return !((m_pend.size() == 2) && (mq.size() == FIFO_DEPTH));
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pend.delete();
        m_shadow = '0;
        m_drop   = 0;
    endtask

    task automatic model_step(input logic v, input logic [71:0] vx, input logic iaw,
                              input logic [15:0] ia, input logic clr, input logic rdy);
        logic        acc;
        logic [15:0] eff;
        tri_t        t;
        acc = v && m_ready();
        eff = iaw ? ia : m_shadow;
        if (rdy && (mq.size() != 0)) void'(mq.pop_front());
        if (clr) begin
            m_pend.delete();
        end else if (acc) begin
            m_pend.push_back(vx);
            if (m_pend.size() == 3) begin
                t.v0 = m_pend[0];
                t.v1 = m_pend[1];
                t.v2 = m_pend[2];
                t.ia = eff;
                if (eff != 16'd0) mq.push_back(t);
                else if (m_drop < 65535) m_drop++;
                m_pend.delete();
            end
        end
        if (iaw) m_shadow = ia;
    endtask

    function automatic logic [231:0] head_act();
        return {v0_x, v0_y, v0_z, v0_color, v1_x, v1_y, v1_z, v1_color,
                v2_x, v2_y, v2_z, v2_color, inv_area};
    endfunction

    function automatic logic [71:0] mkv(input logic [15:0] x, input logic [15:0] y);
        return {x, y, x ^ 16'h5A5A, {8'hC3, y}};
    endfunction

    task automatic model_check(input string tag);
        chk({tag, "_ready"}, 256'(vtx_ready), 256'(m_ready()));
        chk({tag, "_valid"}, 256'(tri_valid), 256'(mq.size() != 0));
        chk({tag, "_count"}, 256'(fifo_count), 256'(mq.size()));
        chk({tag, "_drop"}, 256'(drop_count), 256'(m_drop));
        if (mq.size() != 0) chk({tag, "_head"}, 256'(head_act()), 256'(mq[0]));
    endtask

    // Drive one cycle from the falling edge; outputs are then sampled on the
    // next falling edge.
    task automatic step(input logic v, input logic [15:0] x, input logic [15:0] y,
                        input logic iaw, input logic [15:0] ia, input logic clr,
                        input logic rdy);
        logic [71:0] vx;
        vx = mkv(x, y);
        vtx_valid = v; {vtx_x, vtx_y, vtx_z, vtx_color} = vx;
        inv_area_wr = iaw; inv_area_in = ia; asm_clear = clr; tri_ready = rdy;
        model_step(v, vx, iaw, ia, clr, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        v;
        logic [15:0] x, y;
        logic        iaw;
        logic [15:0] ia;
        logic        clr, rdy;
        logic        e_tv;
        int          e_cnt, e_drop;
        logic        e_ready;
        logic [15:0] e_v1x, e_ia;
    } vec_t;

    vec_t tbl[19];

    initial begin
        tbl[0]  = '{0, 16'h0000, 16'h0000, 1, 16'h0800, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000};
        tbl[1]  = '{1, 16'h0100, 16'h0100, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000};
        tbl[2]  = '{1, 16'h0500, 16'h0100, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000};
        tbl[3]  = '{1, 16'h0100, 16'h0500, 0, 16'h0000, 0, 0, 1, 1, 0, 1, 16'h0500, 16'h0800};
        tbl[4]  = '{0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1, 0, 0, 0, 1, 16'h0000, 16'h0000};
        tbl[5]  = '{0, 16'h0000, 16'h0000, 1, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000};
        tbl[6]  = '{1, 16'h0200, 16'h0200, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000};
        tbl[7]  = '{1, 16'h0300, 16'h0200, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000};
        tbl[8]  = '{1, 16'h0200, 16'h0300, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 16'h0000, 16'h0000};
        tbl[9]  = '{1, 16'h0400, 16'h0400, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 16'h0000, 16'h0000};
        tbl[10] = '{1, 16'h0600, 16'h0400, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 16'h0000, 16'h0000};
        tbl[11] = '{1, 16'h0400, 16'h0600, 1, 16'h0100, 0, 0, 1, 1, 1, 1, 16'h0600, 16'h0100};
        tbl[12] = '{1, 16'h0700, 16'h0100, 0, 16'h0000, 0, 0, 1, 1, 1, 1, 16'h0600, 16'h0100};
        tbl[13] = '{1, 16'h0800, 16'h0100, 0, 16'h0000, 0, 0, 1, 1, 1, 1, 16'h0600, 16'h0100};
        tbl[14] = '{1, 16'h0900, 16'h0100, 0, 16'h0000, 1, 0, 1, 1, 1, 1, 16'h0600, 16'h0100};
        tbl[15] = '{1, 16'h0A00, 16'h0100, 0, 16'h0000, 0, 0, 1, 1, 1, 1, 16'h0600, 16'h0100};
        tbl[16] = '{1, 16'h0B00, 16'h0200, 0, 16'h0000, 0, 0, 1, 1, 1, 1, 16'h0600, 16'h0100};
        tbl[17] = '{1, 16'h0C00, 16'h0300, 0, 16'h0000, 0, 1, 1, 1, 1, 1, 16'h0B00, 16'h0100};
        tbl[18] = '{0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1, 0, 0, 1, 1, 16'h0000, 16'h0000};
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [71:0] va, vb, vc, vd, ve;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 256'(vtx_ready), 256'(1));
        chk("rst_valid", 256'(tri_valid), 256'(0));
        chk("rst_count", 256'(fifo_count), 256'(0));
        chk("rst_drop", 256'(drop_count), 256'(0));
        chk("rst_head", 256'(head_act()), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].iaw, tbl[i].ia, tbl[i].clr, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), 256'(tri_valid), 256'(tbl[i].e_tv));
            chk($sformatf("tbl%0d_count", i), 256'(fifo_count), 256'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_drop", i), 256'(drop_count), 256'(tbl[i].e_drop));
            chk($sformatf("tbl%0d_ready", i), 256'(vtx_ready), 256'(tbl[i].e_ready));
            if (tbl[i].e_tv) begin
                chk($sformatf("tbl%0d_v1x", i), 256'(v1_x), 256'(tbl[i].e_v1x));
                chk($sformatf("tbl%0d_ia", i), 256'(inv_area), 256'(tbl[i].e_ia));
            end
        end
        model_check("tbl_end");

        // Fill the FIFO with tri_ready low: 14 vertices -> 4 triangles + 2 staged
        for (int i = 0; i < 3 * FIFO_DEPTH + 2; i++) begin
            step(1, 16'(16'h1000 + i * 16'h0010), 16'(16'h2000 + i), 0, 0, 0, 0);
            model_check($sformatf("fill%0d", i));
        end
        chk("full_count", 256'(fifo_count), 256'(FIFO_DEPTH));
        chk("full_ready", 256'(vtx_ready), 256'(0));
        // 15th vertex is held while stalled
        repeat (2) begin
            step(1, 16'h1F00, 16'h2F00, 0, 0, 0, 0);
            model_check("stall");
        end
        // Pop pulse: ready stays low during the pulse, vertex lands next cycle
        step(1, 16'h1F00, 16'h2F00, 0, 0, 0, 1);
        model_check("stall_pop");
        chk("stall_pop_count", 256'(fifo_count), 256'(FIFO_DEPTH - 1));
        step(1, 16'h1F00, 16'h2F00, 0, 0, 0, 0);
        model_check("stall_take");
        chk("stall_take_count", 256'(fifo_count), 256'(FIFO_DEPTH));
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            step(0, 0, 0, 0, 0, 0, 1);
            model_check($sformatf("drain%0d", i));
        end

        // Reset mid-operation: 2 entries queued plus 2 staged vertices
        for (int i = 0; i < 8; i++) step(1, 16'(16'h3000 + i), 16'h3100, 0, 0, 0, 0);
        chk("prerst_count", 256'(fifo_count), 256'(2));
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_valid", 256'(tri_valid), 256'(0));
        chk("midrst_count", 256'(fifo_count), 256'(0));
        chk("midrst_ready", 256'(vtx_ready), 256'(1));
        chk("midrst_head", 256'(head_act()), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 16'h4000, 16'h4100, 0, 0, 0, 0);
        step(1, 16'h4200, 16'h4300, 0, 0, 0, 0);
        step(1, 16'h4400, 16'h4500, 1, 16'h0300, 0, 0);
        model_check("postrst");
        chk("postrst_head", 256'(head_act()),
            256'({mkv(16'h4000, 16'h4100), mkv(16'h4200, 16'h4300), mkv(16'h4400, 16'h4500), 16'h0300}));
        step(0, 0, 0, 0, 0, 0, 1);

        // Random phase
        for (int i = 0; i < 400; i++) begin
            logic        rv, riaw, rclr, rrdy;
            logic [15:0] ria;
            rv   = ($urandom_range(0, 3) != 0);
            riaw = ($urandom_range(0, 7) == 0);
            ria  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            rclr = ($urandom_range(0, 31) == 0);
            rrdy = ($urandom_range(0, 2) == 0);
            step(rv, 16'($urandom), 16'($urandom), riaw, ria, rclr, rrdy);
            model_check($sformatf("rnd%0d", i));
        end

`ifdef TRI_STRIP_EN
        // Strip A,B,C,D,E -> (A,B,C), (C,B,D), (C,D,E)
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        strip_mode = 1'b1;
        va = mkv(16'h0100, 16'h0100);
        vb = mkv(16'h0500, 16'h0100);
        vc = mkv(16'h0100, 16'h0500);
        vd = mkv(16'h0500, 16'h0500);
        ve = mkv(16'h0100, 16'h0900);
        step(1, 16'h0100, 16'h0100, 1, 16'h0100, 0, 0);
        step(1, 16'h0500, 16'h0100, 0, 0, 0, 0);
        step(1, 16'h0100, 16'h0500, 0, 0, 0, 0);
        step(1, 16'h0500, 16'h0500, 0, 0, 0, 0);
        step(1, 16'h0100, 16'h0900, 0, 0, 0, 0);
        chk("strip_count", 256'(fifo_count), 256'(3));
        chk("strip_t0", 256'(head_act()), 256'({va, vb, vc, 16'h0100}));
        step(0, 0, 0, 0, 0, 0, 1);
        chk("strip_t1", 256'(head_act()), 256'({vc, vb, vd, 16'h0100}));
        step(0, 0, 0, 0, 0, 0, 1);
        chk("strip_t2", 256'(head_act()), 256'({vc, vd, ve, 16'h0100}));
        step(0, 0, 0, 0, 0, 0, 1);
        strip_mode = 1'b0;
`else
        va = '0; vb = '0; vc = '0; vd = '0; ve = '0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
